// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file write-port scheduler.
//  - AW, DW, DEPTH: default geometry of the 8x16 register file.
//  - state_e: scheduler state encoding (arbitrate vs. clear sweep).
//  - rr_next: round-robin successor of an index, modulo n.
package regfile_pkg;

  localparam int unsigned AW    = 3;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Index following idx in a ring of n entries.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//  req    in   N    request vector
//  ptr    in   IW   highest-priority index this cycle (must be < N)
//  gnt    out  N    one-hot grant, zero when no request
//  gntIdx out  IW   index of the granted request, zero when none
//  anyGnt out  1    some request is granted
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gntIdx,
  output logic          anyGnt
);

  int unsigned idx;

  // Scan from the farthest candidate to the nearest so the last hit, i.e. the
  // first set bit at or after ptr (wrapping), is the one that sticks.
  always_comb begin
    gnt    = '0;
    gntIdx = '0;
    anyGnt = 1'b0;
    idx    = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr) + (N - 1 - k);
      if (idx >= N) begin
        idx = idx - N;
      end
      if (req[IW'(idx)]) begin
        gnt            = '0;
        gnt[IW'(idx)]  = 1'b1;
        gntIdx         = IW'(idx);
        anyGnt         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wr_sched.sv
// Write-port scheduler for the 8x16 register file.
// Shares the file's single write port among NREQ requesters (round-robin) and
// runs an on-demand sweep that writes zero to every entry.
//  clk       in   1        rising-edge clock
//  reset     in   1        asynchronous, active-high reset
//  reqValid  in   NREQ     requester i holds a write pending
//  reqAddr   in   NREQ*AW  requester i address, slice [i*AW +: AW]
//  reqData   in   NREQ*DW  requester i data, slice [i*DW +: DW]
//  reqReady  out  NREQ     one-hot acceptance (combinational)
//  clrStart  in   1        starts a clear sweep
//  clrBusy   out  1        high alongside every clear write
//  clrDone   out  1        high alongside the write to DEPTH-1
//  write     out  1        register file write enable (registered)
//  wrAddr    out  AW       register file write address (registered)
//  wrData    out  DW       register file write data (registered)
module regfile_wr_sched #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned AW    = regfile_pkg::AW,
  parameter int unsigned DW    = regfile_pkg::DW,
  parameter int unsigned DEPTH = regfile_pkg::DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    reqValid,
  input  logic [NREQ*AW-1:0] reqAddr,
  input  logic [NREQ*DW-1:0] reqData,
  output logic [NREQ-1:0]    reqReady,
  input  logic               clrStart,
  output logic               clrBusy,
  output logic               clrDone,
  output logic               write,
  output logic [AW-1:0]      wrAddr,
  output logic [DW-1:0]      wrData
);

  import regfile_pkg::*;

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // One spare bit so the sweep never relies on address wrap.
  localparam int unsigned CW = AW + 1;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            write_q, write_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            any_gnt;
  logic            arb_en;
  logic            clr_last;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  rr_arbiter #(
    .N  (NREQ),
    .IW (PW)
  ) u_arb (
    .req    (reqValid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gntIdx (gnt_idx),
    .anyGnt (any_gnt)
  );

  // Grants are only offered while arbitrating; a clear request pre-empts them.
  assign arb_en   = (state_q == ST_ARB) && !clrStart && !reset;
  assign clr_last = (cnt_q == CW'(DEPTH - 1));

  // One-hot data mux for the granted requester.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_addr = reqAddr[i*AW +: AW];
        sel_data = reqData[i*DW +: DW];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ARB;
      ptr_q     <= '0;
      cnt_q     <= '0;
      write_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      write_q   <= write_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_ARB: begin
        if (clrStart) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + CW'(1);
        if (clr_last) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Output and datapath logic.
  always_comb begin
    reqReady  = '0;
    write_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ptr_d     = ptr_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        if (arb_en && any_gnt) begin
          reqReady  = gnt;
          write_d   = 1'b1;
          wr_addr_d = sel_addr;
          wr_data_d = sel_data;
          ptr_d     = PW'(rr_next(32'(gnt_idx), NREQ));
        end
      end
      ST_CLEAR: begin
        write_d   = 1'b1;
        wr_addr_d = cnt_q[AW-1:0];
        wr_data_d = '0;
        busy_d    = 1'b1;
        done_d    = clr_last;
      end
      default: ;
    endcase
  end

  assign write   = write_q;
  assign wrAddr  = wr_addr_q;
  assign wrData  = wr_data_q;
  assign clrBusy = busy_q;
  assign clrDone = done_q;

endmodule
